// File: rtl/range_pkg.sv
// Shared types and constant helpers for the ultrasonic range sequencer.
// Widths and tick counts are derived from the top-level parameters through these functions.
package range_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_e;

  localparam int DIST_W = 16;
  localparam int SUM_W  = 18;
  localparam int AVG_N  = 4;

  function automatic int cyc_per_us(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  function automatic int period_ticks(input int period_ms);
    return period_ms * 1000;
  endfunction

  // Bits needed to hold the values 0 .. n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/range_sequencer_if.sv
// Sensor/host-facing signal bundle of the range sequencer.
// The slave modport is the sequencer itself; the master side drives Enable and the raw echo.
interface range_sequencer_if;
  import range_pkg::*;

  logic              Enable;
  logic              Echo;
  logic              Trig;
  logic [DIST_W-1:0] Dist;
  logic              Dist_Valid;
  logic              Err;
  logic              Busy;

  modport slave (
    input  Enable,
    input  Echo,
    output Trig,
    output Dist,
    output Dist_Valid,
    output Err,
    output Busy
  );

  modport master (
    output Enable,
    output Echo,
    input  Trig,
    input  Dist,
    input  Dist_Valid,
    input  Err,
    input  Busy
  );

endinterface

// File: rtl/range_sequencer_us_tick_gen.sv
// Microsecond tick divider: one-cycle pulse every DIV clocks.
// A synchronous restart realigns the phase so tick-counted intervals start on a known edge.
module us_tick_gen
  import range_pkg::*;
#(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/range_sequencer.sv
// Ultrasonic ranging controller: periodic trigger, echo timing, cm conversion, timeout flagging.
// Define RANGE_AVG_EN to report a 4-sample running mean instead of the raw distance.
module range_sequencer
  import range_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 25000,
  parameter int US_PER_CM  = 58,
  parameter int MAX_CM     = 400
) (
  input  logic              Clk,
  input  logic              Rst,
  range_sequencer_if.slave  bus
);

  localparam int DIV       = cyc_per_us(CLK_HZ);
  localparam int PERIOD_US = period_ticks(PERIOD_MS);
  localparam int US_W      = cnt_w(max2(TRIG_US, TIMEOUT_US));
  localparam int PER_W     = cnt_w(PERIOD_US);
  localparam int SUB_W     = cnt_w(US_PER_CM);
  localparam int CM_W      = cnt_w(MAX_CM + 1);

  localparam logic [US_W-1:0]  TRIG_LAST = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]  TO_LAST   = US_W'(TIMEOUT_US - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_US - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(US_PER_CM - 1);
  localparam logic [CM_W-1:0]  CM_MAX    = CM_W'(MAX_CM);

  // Both timeout windows plus the trigger must fit inside one period.
  if (TRIG_US + 2 * TIMEOUT_US >= PERIOD_US) begin : g_param_chk
    $error("range_sequencer: TRIG_US + 2*TIMEOUT_US must be below PERIOD_MS*1000");
  end

  function automatic logic [CM_W-1:0] sat_cm_inc(input logic [CM_W-1:0] v);
    return (v >= CM_MAX) ? CM_MAX : v + CM_W'(1);
  endfunction

  logic              tick, tick_restart;
  logic              echo_s1_q, echo_s2_q, echo_s3_q;
  logic              echo_rise, echo_fall;
  state_e            state_q, state_d;
  logic              trig_q, trig_d;
  logic [US_W-1:0]   us_q, us_d, us_inc;
  logic [PER_W-1:0]  per_q, per_d;
  logic [SUB_W-1:0]  sub_q, sub_d, sub_nx;
  logic [CM_W-1:0]   cm_q, cm_d, cm_nx;
  logic              err_q, err_d;
  logic              good;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              dist_vld_q, dist_vld_d;

  us_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (Clk),
    .rst_n   (Rst),
    .restart (tick_restart),
    .tick    (tick)
  );

  // Two-flop synchronizer; the third flop only serves edge detection.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
    end else begin
      echo_s1_q <= bus.Echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
    end
  end

  assign echo_rise = echo_s2_q & ~echo_s3_q;
  assign echo_fall = ~echo_s2_q & echo_s3_q;

  // Next counter values include the current cycle's tick, so a capture on
  // the fall edge accounts for the full echo width.
  always_comb begin
    us_inc = tick ? us_q + US_W'(1) : us_q;
    sub_nx = sub_q;
    cm_nx  = cm_q;
    if (tick) begin
      if (sub_q == SUB_LAST) begin
        sub_nx = '0;
        cm_nx  = sat_cm_inc(cm_q);
      end else begin
        sub_nx = sub_q + SUB_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    us_d    = us_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    per_d   = (tick && per_q != PER_LAST) ? per_q + PER_W'(1) : per_q;
    err_d   = err_q;
    good    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Enable) begin
          state_d = TRIG;
          us_d    = '0;
          per_d   = '0;
        end
      end
      TRIG: begin
        us_d = us_inc;
        if (tick && us_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          us_d    = '0;
        end
      end
      WAIT_RISE: begin
        us_d = us_inc;
        if (echo_rise) begin
          state_d = MEASURE;
          us_d    = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else if (tick && us_q == TO_LAST) begin
          state_d = HOLDOFF;
          err_d   = 1'b1;
        end
      end
      MEASURE: begin
        us_d  = us_inc;
        sub_d = sub_nx;
        cm_d  = cm_nx;
        if (echo_fall) begin
          state_d = HOLDOFF;
          good    = 1'b1;
          err_d   = 1'b0;
        end else if (tick && us_q == TO_LAST) begin
          state_d = HOLDOFF;
          err_d   = 1'b1;
        end
      end
      HOLDOFF: begin
        if (tick && per_q == PER_LAST) begin
          state_d = TRIG;
          us_d    = '0;
          per_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropping Enable aborts from anywhere, keeping the reported result and flag.
    if (!bus.Enable) begin
      state_d = IDLE;
      good    = 1'b0;
      err_d   = err_q;
    end
  end

  assign trig_d       = (state_d == TRIG);
  assign tick_restart = (state_d == TRIG) && (state_q != TRIG);

`ifdef RANGE_AVG_EN
  logic [DIST_W-1:0] win_q [AVG_N];
  logic [DIST_W-1:0] win_d [AVG_N];
  logic              filled_q, filled_d;
  logic              avg_vld_q, avg_vld_d;
  logic [SUM_W-1:0]  win_sum;

  function automatic logic [DIST_W-1:0] avg_div4(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:2];
  endfunction

  // The first good sample seeds every slot so the mean starts at that value.
  always_comb begin
    win_d     = win_q;
    filled_d  = filled_q | good;
    avg_vld_d = good;
    if (good) begin
      if (!filled_q) begin
        for (int i = 0; i < AVG_N; i++) win_d[i] = DIST_W'(cm_nx);
      end else begin
        for (int i = AVG_N - 1; i > 0; i--) win_d[i] = win_q[i-1];
        win_d[0] = DIST_W'(cm_nx);
      end
    end
    win_sum    = SUM_W'(win_q[0]) + SUM_W'(win_q[1]) + SUM_W'(win_q[2]) + SUM_W'(win_q[3]);
    dist_d     = avg_vld_q ? avg_div4(win_sum) : dist_q;
    dist_vld_d = avg_vld_q;
  end

  always_ff @(posedge Clk) begin
    win_q <= win_d;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      filled_q  <= 1'b0;
      avg_vld_q <= 1'b0;
    end else begin
      filled_q  <= filled_d;
      avg_vld_q <= avg_vld_d;
    end
  end
`else
  always_comb begin
    dist_d     = good ? DIST_W'(cm_nx) : dist_q;
    dist_vld_d = good;
  end
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      trig_q     <= 1'b0;
      us_q       <= '0;
      per_q      <= '0;
      sub_q      <= '0;
      cm_q       <= '0;
      err_q      <= 1'b0;
      dist_q     <= '0;
      dist_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      us_q       <= us_d;
      per_q      <= per_d;
      sub_q      <= sub_d;
      cm_q       <= cm_d;
      err_q      <= err_d;
      dist_q     <= dist_d;
      dist_vld_q <= dist_vld_d;
    end
  end

  assign bus.Trig       = trig_q;
  assign bus.Dist       = dist_q;
  assign bus.Dist_Valid = dist_vld_q;
  assign bus.Err        = err_q;
  assign bus.Busy       = (state_q != IDLE);

endmodule

// File: doc/range_sequencer.md
# range_sequencer

Measurement controller for the ultrasonic ranging front end. Issues periodic trigger pulses, synchronizes and times the returning echo, converts echo width to centimetres, and presents a held 16-bit distance word with a one-cycle valid strobe. The downstream seven-segment and VGA display paths consume that word. Timeout and stuck-echo conditions are flagged instead of producing bogus distances.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- TRIG_US, 10, trigger pulse width in µs
- PERIOD_MS, 60, trigger-start to trigger-start interval
- TIMEOUT_US, 25000, max wait for echo rise, and max echo-high time
- US_PER_CM, 58, echo µs per cm of range
- MAX_CM, 400, distance saturation value
- Clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- Enable  in  1  level; 1 = run periodic measurements
- Echo  in  1  asynchronous sensor echo; synchronized internally
- Trig  out  1  sensor trigger, registered
- Dist  out  16  last good distance in cm, held
- Dist_Valid  out  1  one-cycle strobe on Dist update
- Err  out  1  sticky timeout flag; cleared by next good measurement
- Busy  out  1  high in any state other than IDLE

## Operation
- Echo passes through a 2-FF synchronizer; an edge detector on the synced signal produces rise and fall pulses.
- A µs tick generator pulses once every CLK_HZ/1_000_000 cycles. It restarts at each TRIG entry.
- FSM states:
  - IDLE: Trig=0. If Enable=1, go to TRIG and start the period counter.
  - TRIG: Trig=1 for TRIG_US ticks, then WAIT_RISE.
  - WAIT_RISE: on a synced rise, clear the µs and cm counters and go to MEASURE. After TIMEOUT_US ticks with no rise, set Err=1 and go to HOLDOFF.
  - MEASURE: the cm counter increments every US_PER_CM ticks and saturates at MAX_CM. On a synced fall, load Dist, pulse Dist_Valid, clear Err, and go to HOLDOFF. After TIMEOUT_US ticks with Echo still high, set Err=1 and go to HOLDOFF.
  - HOLDOFF: when the period counter reaches PERIOD_MS·1000 µs, go to TRIG if Enable=1, else IDLE.
- Dist = floor(echo_µs / US_PER_CM), capped at MAX_CM. Counters are sized by $clog2 of the derived constants.
- Echo already high when TRIG ends: only a fresh rise is accepted, so this resolves as a WAIT_RISE timeout.
- Enable=0 in any state: abort to IDLE on the next edge. Trig drops, no Dist_Valid is issued, and Dist and Err are held.
- Reset values: Trig=0, Dist=0, Dist_Valid=0, Err=0, Busy=0, state=IDLE.
- Required parameter constraint: TRIG_US + 2·TIMEOUT_US < PERIOD_MS·1000. Checked by a static assertion.

## Timing
- Trig is high for exactly TRIG_US·CLK_HZ/1e6 cycles: 500 at default parameters.
- Echo-to-internal latency is 2 cycles. Dist and Dist_Valid update 3 cycles after the physical Echo falling edge.
- Trig rising edges are spaced exactly PERIOD_MS·CLK_HZ/1000 cycles apart while Enable remains 1.
- Reset assertion mid-operation takes effect immediately (asynchronous). Deassertion is followed by IDLE and, if Enable=1, the first Trig on the next edge.

## Configuration
- RANGE_AVG_EN defined:
  - Dist is the running mean of the last 4 good samples: 18-bit sum >> 2.
  - The first good sample after reset pre-fills all 4 slots.
  - Timeouts do not enter the window.
  - Dist_Valid is delayed 1 extra cycle.
- RANGE_AVG_EN undefined: Dist is the raw sample, and the averaging logic is absent.

## Structure
- range_pkg holds:
  - the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF)
  - localparam helpers for cycles-per-µs, trigger/period/timeout tick counts and counter widths.
- Sub-module us_tick_gen: parameterized divider producing the µs pulse, with a synchronous restart input.

## Test plan
Bench runs CLK_HZ=1_000_000 and PERIOD_MS=60 unless noted.
- Echo high 5800 µs after Trig → Dist=100, single Dist_Valid, Err=0.
- Echo high 30000 µs → Dist=400 is not produced; instead Err=1 at 25000 µs into MEASURE, no Dist_Valid, Dist holds its previous value.
- Echo never rises → Err=1 exactly 25000 µs after TRIG end. Next Trig occurs 60000 µs after the previous one. A following 1160 µs echo gives Dist=20 and Err=0.
- Enable dropped mid-MEASURE → IDLE next cycle, Trig=0, no strobe. Re-enabling yields a Trig on the following cycle.
- Rst pulsed low mid-TRIG → Trig=0 immediately and all outputs at their reset values.
- With RANGE_AVG_EN, good samples 100, 100, 200, 200 cm → Dist sequence 100, 100, 125, 150.
